// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes and the sequencer state encoding.
package alu_pkg;

  localparam int FUNC_W_DEF = 6;

  // ALU function codes. The sequencer passes these through untouched.
  localparam logic [FUNC_W_DEF-1:0] FN_SLL  = 6'b000000;
  localparam logic [FUNC_W_DEF-1:0] FN_ADDU = 6'b100001;
  localparam logic [FUNC_W_DEF-1:0] FN_SUB  = 6'b100010;
  localparam logic [FUNC_W_DEF-1:0] FN_XOR  = 6'b100110;
  localparam logic [FUNC_W_DEF-1:0] FN_SLT  = 6'b101010;
  localparam logic [FUNC_W_DEF-1:0] FN_BEQ  = 6'b111000;
  localparam logic [FUNC_W_DEF-1:0] FN_BNE  = 6'b111001;
  localparam logic [FUNC_W_DEF-1:0] FN_LUI  = 6'b111101;

  // Idle value on the ALU function bus: an add has no side effects.
  localparam logic [FUNC_W_DEF-1:0] FN_IDLE = FN_ADDU;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester handshake plus ALU operand/result bus of the shared-ALU sequencer.
interface alu_share_ctrl_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*FUNC_W-1:0] req_func;

  logic [DATA_W-1:0]       alu_in1;
  logic [DATA_W-1:0]       alu_in2;
  logic [FUNC_W-1:0]       alu_func;
  logic [DATA_W-1:0]       alu_out;
  logic                    alu_zero;

  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_zero;

  logic                    busy;

  // Environment side: requesters and the ALU itself.
  modport master (
    output req_valid, req_a, req_b, req_func, rsp_ready, alu_out, alu_zero,
    input  req_ready, alu_in1, alu_in2, alu_func, rsp_valid, rsp_data, rsp_zero, busy
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, req_func, rsp_ready, alu_out, alu_zero,
    output req_ready, alu_in1, alu_in2, alu_func, rsp_valid, rsp_data, rsp_zero, busy
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: the first pending request at or above the pointer wins,
// wrapping past the top index.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Scan all slots starting at the pointer; only the first hit is granted.
  always_comb begin
    int slot;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    slot      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      slot = int'(ptr) + k;
      if (slot >= N_REQ) slot = slot - N_REQ;
      if (!grant_any && req[slot]) begin
        grant[slot] = 1'b1;
        grant_idx   = IDX_W'(slot);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one registered ALU between N_REQ requesters: round-robin grant,
// drive operands, wait out the ALU latency, return out/zero to the winner.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 32,
  parameter int FUNC_W  = 6,
  parameter int ALU_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  alu_share_ctrl_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = ($clog2(ALU_LAT + 1) > 1) ? $clog2(ALU_LAT + 1) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   in1_q, in1_d;
  logic [DATA_W-1:0]   in2_q, in2_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                zero_q, zero_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;

  logic [N_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [N_REQ-1:0]    gidx_oh;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign gidx_oh = N_REQ'(1) << gidx_q;

  // Next-state and datapath-register updates for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    func_d      = func_q;
    data_d      = data_q;
    zero_d      = zero_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          in1_d   = bus.req_a[int'(arb_idx) * DATA_W +: DATA_W];
          in2_d   = bus.req_b[int'(arb_idx) * DATA_W +: DATA_W];
          func_d  = bus.req_func[int'(arb_idx) * FUNC_W +: FUNC_W];
          gidx_d  = arb_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // WAIT runs ALU_LAT+1 edges so the capture lands on edge accept+2+ALU_LAT.
        cnt_d   = CNT_W'(ALU_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          data_d      = bus.alu_out;
          zero_d      = bus.alu_zero;
          rsp_valid_d = gidx_oh;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        // Only the granted requester's ready counts; others are ignored.
        if (bus.rsp_ready[gidx_q]) begin
          rsp_valid_d = '0;
          ptr_d       = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      cnt_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      func_q      <= FUNC_W'(FN_IDLE);
      data_q      <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      func_q      <= func_d;
      data_q      <= data_d;
      zero_q      <= zero_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Acceptance is combinational in IDLE and suppressed while reset is held.
  assign bus.req_ready = (state_q == ST_IDLE && !rst) ? arb_grant : '0;
  assign bus.alu_in1   = in1_q;
  assign bus.alu_in2   = in2_q;
  assign bus.alu_func  = func_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.busy      = busy_q;

endmodule
